// File: rtl/rv32_instr_encoder.sv
// RV32I field packer: encodes one request per accept, tags it with a word address and
// queues it in a DEPTH-entry FIFO. Optional per-entry parity output under `ENC_PARITY_EN.
module rv32_instr_encoder #(
    parameter int          DEPTH    = 2,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
`ifdef ENC_PARITY_EN
    output logic              out_parity,
`endif
    output logic              err,
    input  logic              clr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [ADDR_W-1:0] tag_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       enc_s, word_s;
    logic              legal_s, push_s, pop_s;

`ifdef ENC_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];

    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction
`endif

    // Field packing and opcode/format legality for the request currently presented.
    always_comb begin
        enc_s   = NOP_WORD;
        legal_s = 1'b0;
        case (fmt)
            3'd0: begin
                enc_s   = {funct7, rs2, rs1, funct3, rd, opcode};
                legal_s = (opcode == 7'b0110011);
            end
            3'd1: begin
                enc_s   = {imm[11:0], rs1, funct3, rd, opcode};
                legal_s = (opcode == 7'b0010011) || (opcode == 7'b0000011) ||
                          (opcode == 7'b1100111);
            end
            3'd2: begin
                enc_s   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal_s = (opcode == 7'b0100011);
            end
            3'd3: begin
                enc_s   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal_s = (opcode == 7'b1100011) && !imm[0];
            end
            3'd4: begin
                enc_s   = {imm[31:12], rd, opcode};
                legal_s = (opcode == 7'b0110111) || (opcode == 7'b0010111);
            end
            3'd5: begin
                enc_s   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal_s = (opcode == 7'b1101111) && !imm[0];
            end
            default: begin
                enc_s   = NOP_WORD;
                legal_s = 1'b0;
            end
        endcase
        word_s = legal_s ? enc_s : NOP_WORD;
    end

    // FIFO bookkeeping, address counter and sticky error; handshake flags come from next state.
    always_comb begin
        push_s   = in_valid && in_ready_q;
        pop_s    = out_valid_q && out_ready;
        mem_d    = mem_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
`ifdef ENC_PARITY_EN
        par_d    = par_q;
`endif
        if (push_s) begin
            mem_d[wr_ptr_q] = word_s;
            tag_d[wr_ptr_q] = addr_q;
`ifdef ENC_PARITY_EN
            par_d[wr_ptr_q] = even_parity(word_s);
`endif
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            addr_d          = addr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // An illegal accept must win over a same-cycle clear.
        if (push_s && !legal_s) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != CNT_W'(0));
    end

    // State registers; reset discards any queued words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: 32'h0000_0000};
            tag_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ENC_PARITY_EN
            par_q       <= '{default: 1'b0};
`endif
        end else begin
            mem_q       <= mem_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ENC_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = mem_q[rd_ptr_q];
    assign out_addr  = tag_q[rd_ptr_q];
    assign err       = err_q;
`ifdef ENC_PARITY_EN
    assign out_parity = par_q[rd_ptr_q];
`endif

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the opcode decoder: packs RV32I instruction fields into a 32-bit instruction word.
- Tags each word with a sequential word address.
- Buffers results in a small output FIFO behind a valid/ready handshake.
- Feeds the instruction-memory loader and test harness, which stream programs into imem without a hex file.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- ADDR_W, 8, width of word address counter
- NOP_WORD, 32'h00000013, word emitted for illegal requests (ADDI x0,x0,0)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- opcode  in  7  opcode[6:0]
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  funct3
- funct7  in  7  funct7 (R only)
- imm  in  32  immediate, sign-extended byte offset or value
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer ready
- out_instr  out  32  encoded word at head
- out_addr  out  ADDR_W  word address of head
- err  out  1  sticky illegal-request flag
- clr_err  in  1  synchronous clear of err

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: FIFO empty, out_valid=0, out_instr=0, out_addr=0, address counter=0, err=0, in_ready=1.
- Ready/accept:
  - in_ready = (count < DEPTH).
  - in_ready is registered state only; no combinational path from out_ready.
  - Accept: encode combinationally, write to FIFO tail at the accept edge.
  - out_valid rises the cycle after acceptance if FIFO was empty (latency 1).
- Output:
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when 0 < count < DEPTH: count unchanged.
  - Pop with count==DEPTH frees a slot; in_ready rises the next cycle.
  - FIFO order is strict; pointers wrap modulo DEPTH.
- Address: counter increments by 1 per accepted request, including illegal ones; wraps 2^ADDR_W−1 → 0.
- Encoding (instr bit fields):
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode
  - I: imm[11:0] | rs1 | funct3 | rd | opcode
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode
  - U: imm[31:12] | rd | opcode
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode
- Legality — opcode must match fmt:
  - R: 0110011
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
- Illegal request (any of the following): fmt 6/7, opcode/fmt mismatch, or B/J with imm[0]=1.
  - Stored word is NOP_WORD.
  - err set at the accept edge.
- err is sticky until clr_err.
  - clr_err and a new illegal accept in the same cycle: err=1 (set wins).
- Reset asserted mid-stream: FIFO and counter cleared immediately; in-flight data discarded.

Optional Feature:
- Macro: ENC_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = even-parity XOR of out_instr, stored per FIFO entry; reset value 0.
- Undefined: port absent, no parity storage.

Test Plan:
- I-type:
  - stimulus: fmt=1, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1
  - response: next cycle out_valid=1, out_instr=0x00500093, out_addr=0
- R, S, B sequence (add x3,x1,x2; sw x2,8(x1); beq x1,x2,+8):
  - response: 0x002081B3, 0x0020A423, 0x00208463 in order; out_addr 0, 1, 2
- U and J:
  - stimulus: lui x5,0x12345000; jal x1,+16
  - response: 0x123452B7, 0x010000EF
- Illegal:
  - stimulus: fmt=0 with opcode=0010011; then jal with imm=3
  - response: both emit 0x00000013, err=1, addresses still increment
  - then: pulse clr_err → err=0
- Backpressure, DEPTH=2:
  - stimulus: out_ready=0, push 3 requests
  - response: in_ready=0 after 2nd accept; 3rd held
  - then: out_ready=1 → 3rd accepted, words drain in order, addresses 0, 1, 2
- Wrap/reset:
  - stimulus: ADDR_W=8, 257 accepts
  - response: last out_addr=0
  - then: assert rst_n=0 with FIFO non-empty → out_valid=0 immediately, counter=0
